// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes, ALUControl modes, function codes and
// the sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLL   = 3'b100;
    localparam logic [2:0] ALU_SRL   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] CTL_ADD    = 2'b00;
    localparam logic [1:0] CTL_SUB    = 2'b01;
    localparam logic [1:0] CTL_DECODE = 2'b10;
    localparam logic [1:0] CTL_PASSB  = 2'b11;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_SLL = 4'b0100;
    localparam logic [3:0] FN_SRL = 4'b0101;
    localparam logic [3:0] FN_SLT = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the multicycle control FSM (master) and
// the ALU op sequencer (slave).
interface alu_op_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int SHAMT_W  = 4,
    parameter int ALUOP_W  = 3
);
    logic                Start;
    logic                Flush;
    logic [1:0]          ALUControl;
    logic [OPCODE_W-1:0] Opcode;
    logic [SHAMT_W-1:0]  ShiftAmt;
    logic [ALUOP_W-1:0]  ALUOpCode;
    logic                FeedbackSel;
    logic                ZeroB;
    logic                ResultValid;
    logic                Busy;
    logic                IllegalOp;

    modport master (
        output Start, Flush, ALUControl, Opcode, ShiftAmt,
        input  ALUOpCode, FeedbackSel, ZeroB, ResultValid, Busy, IllegalOp
    );

    modport slave (
        input  Start, Flush, ALUControl, Opcode, ShiftAmt,
        output ALUOpCode, FeedbackSel, ZeroB, ResultValid, Busy, IllegalOp
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUControl/Opcode decode; shared with the single-cycle datapath.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [1:0]          i_alu_control,
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [2:0]          o_aluop,
    output logic                o_is_shift,
    output logic                o_illegal
);
    logic w_upper;

    assign w_upper = (i_opcode >> 4) != '0;

    always_comb begin
        o_aluop    = ALU_ADD;
        o_is_shift = 1'b0;
        o_illegal  = 1'b0;
        case (i_alu_control)
            CTL_ADD:   o_aluop = ALU_ADD;
            CTL_SUB:   o_aluop = ALU_SUB;
            CTL_PASSB: o_aluop = ALU_PASSB;
            default: begin
                if (w_upper) begin
                    o_aluop   = ALU_PASSB;
                    o_illegal = 1'b1;
                end else begin
                    case (i_opcode[3:0])
                        FN_ADD: o_aluop = ALU_ADD;
                        FN_SUB: o_aluop = ALU_SUB;
                        FN_AND: o_aluop = ALU_AND;
                        FN_OR:  o_aluop = ALU_OR;
                        FN_SLL: begin o_aluop = ALU_SLL; o_is_shift = 1'b1; end
                        FN_SRL: begin o_aluop = ALU_SRL; o_is_shift = 1'b1; end
                        FN_SLT: o_aluop = ALU_SLT;
                        default: begin
                            o_aluop   = ALU_PASSB;
                            o_illegal = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU op sequencer: one request at a time, single-cycle
// ops in EXEC, shifts iterated one bit per cycle in SHIFT.
//
// state | meaning
// IDLE  | waiting for Start; outputs cleared, ALUOpCode holds last value
// EXEC  | one-cycle op, ResultValid high
// SHIFT | iterating shifter, counter holds remaining cycles
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int SHAMT_W  = 4
) (
    input  logic             CLK,
    input  logic             Reset_n,
    alu_op_sequencer_if.slave bus
);
    state_t             r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2:0]         r_aluop;
    logic               r_fb;
    logic               r_zerob;
    logic               r_valid;
    logic               r_busy;
    logic               r_illegal;

    logic [2:0]         w_aluop;
    logic               w_is_shift;
    logic               w_illegal;

    alu_op_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .i_alu_control (bus.ALUControl),
        .i_opcode      (bus.Opcode),
        .o_aluop       (w_aluop),
        .o_is_shift    (w_is_shift),
        .o_illegal     (w_illegal)
    );

    // Outputs are registered for the cycle being entered, so ResultValid of
    // the last shift is armed one iteration early (counter==2 or entry with 1).
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_aluop   <= ALU_ADD;
            r_fb      <= 1'b0;
            r_zerob   <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            if (bus.Flush) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_fb    <= 1'b0;
                r_zerob <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.Start) begin
                            r_busy <= 1'b1;
                            r_fb   <= 1'b0;
                            if (w_is_shift && bus.ShiftAmt != '0) begin
                                r_state <= ST_SHIFT;
                                r_cnt   <= bus.ShiftAmt;
                                r_aluop <= w_aluop;
                                r_zerob <= 1'b0;
                                r_valid <= (bus.ShiftAmt == SHAMT_W'(1));
                            end else if (w_is_shift) begin
                                r_state <= ST_EXEC;
                                r_aluop <= ALU_OR;
                                r_zerob <= 1'b1;
                                r_valid <= 1'b1;
                            end else begin
                                r_state   <= ST_EXEC;
                                r_aluop   <= w_aluop;
                                r_zerob   <= 1'b0;
                                r_valid   <= 1'b1;
                                r_illegal <= w_illegal;
                            end
                        end
                    end
                    ST_EXEC: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_zerob <= 1'b0;
                        r_fb    <= 1'b0;
                    end
                    ST_SHIFT: begin
                        if (r_cnt == SHAMT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_fb    <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt - SHAMT_W'(1);
                            r_fb    <= 1'b1;
                            r_valid <= (r_cnt == SHAMT_W'(2));
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ALUOpCode   = r_aluop;
    assign bus.FeedbackSel = r_fb;
    assign bus.ZeroB       = r_zerob;
    assign bus.ResultValid = r_valid;
    assign bus.Busy        = r_busy;
    assign bus.IllegalOp   = r_illegal;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random
// requests compared cycle by cycle against a transaction-level model.
module tb_alu_op_sequencer;
    logic CLK;
    logic Reset_n;

    alu_op_sequencer_if #(.OPCODE_W(4), .SHAMT_W(4), .ALUOP_W(3)) bus ();

    alu_op_sequencer #(.OPCODE_W(4), .SHAMT_W(4)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] op;
        logic       fb;
        logic       zb;
        logic       rv;
        logic       busy;
        logic       ill;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] m_last_op;
    obs_t m_q[$];

    function automatic obs_t observe();
        obs_t o;
        o.op   = bus.ALUOpCode;
        o.fb   = bus.FeedbackSel;
        o.zb   = bus.ZeroB;
        o.rv   = bus.ResultValid;
        o.busy = bus.Busy;
        o.ill  = bus.IllegalOp;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic [2:0] op);
        obs_t o;
        o = '0;
        o.op = op;
        return o;
    endfunction

    // Behavioural model: the whole expected per-cycle trace of one request.
    function automatic void model_request(input logic [1:0] ctl, input logic [3:0] opc,
                                          input logic [3:0] amt);
        int   op;
        bit   ill;
        obs_t o;
        ill = 0;
        case (ctl)
            2'd0: op = 0;
            2'd1: op = 1;
            2'd3: op = 7;
            default: begin
                if (opc <= 4'd6) op = int'(opc);
                else begin op = 7; ill = 1; end
            end
        endcase
        m_q.delete();
        if ((op == 4 || op == 5) && amt != 0) begin
            for (int i = 0; i < int'(amt); i++) begin
                o = '0;
                o.op = 3'(op);
                o.fb = (i > 0);
                o.rv = (i == int'(amt) - 1);
                o.busy = 1'b1;
                m_q.push_back(o);
            end
        end else begin
            o = '0;
            o.op   = (op == 4 || op == 5) ? 3'd3 : 3'(op);
            o.zb   = (op == 4 || op == 5);
            o.rv   = 1'b1;
            o.busy = 1'b1;
            o.ill  = ill;
            m_q.push_back(o);
        end
    endfunction

    task automatic run_op(input logic [1:0] ctl, input logic [3:0] opc,
                          input logic [3:0] amt, input string tag);
        obs_t act;
        model_request(ctl, opc, amt);
        @(negedge CLK);
        bus.ALUControl = ctl;
        bus.Opcode     = opc;
        bus.ShiftAmt   = amt;
        bus.Start      = 1'b1;
        for (int i = 0; i < m_q.size(); i++) begin
            @(negedge CLK);
            if (i == 0) bus.Start = 1'b0;
            act = observe();
            n_checks++;
            if (act !== m_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b want %b", tag, i, act, m_q[i]);
            end
        end
        m_last_op = m_q[m_q.size()-1].op;
        @(negedge CLK);
        act = observe();
        n_checks++;
        if (act !== idle_obs(m_last_op)) begin
            n_fail++;
            $display("FAIL %s idle: got %b want %b", tag, act, idle_obs(m_last_op));
        end
    endtask

    task automatic test_reset();
        obs_t act;
        act = observe();
        n_checks++;
        if (act !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", act, obs_t'(0));
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        // Reset in the 3rd cycle of a 9-cycle shift
        @(negedge CLK);
        bus.ALUControl = 2'b10;
        bus.Opcode     = 4'b0100;
        bus.ShiftAmt   = 4'd9;
        bus.Start      = 1'b1;
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        act = observe();
        n_checks++;
        if (act !== 8'b100_1_0_0_1_0) begin
            n_fail++;
            $display("FAIL reset_pre_shift3: got %b want %b", act, 8'b100_1_0_0_1_0);
        end
        #1 Reset_n = 1'b0;
        #1 act = observe();
        n_checks++;
        if (act !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got %b want %b", act, obs_t'(0));
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        m_last_op = 3'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            act = observe();
            n_checks++;
            if (act !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_after_release cycle %0d: got %b want %b", i, act, obs_t'(0));
            end
        end
    endtask

    task automatic test_single_cycle();
        run_op(2'b10, 4'b0011, 4'd0, "single_or");
        run_op(2'b00, 4'b0110, 4'd3, "single_add");
        run_op(2'b01, 4'b0000, 4'd0, "single_sub");
        run_op(2'b11, 4'b0001, 4'd7, "single_passb");
        run_op(2'b10, 4'b0110, 4'd2, "single_slt");
        run_op(2'b10, 4'b0010, 4'd0, "single_and");
    endtask

    task automatic test_shift();
        run_op(2'b10, 4'b0100, 4'd5,  "shift_sll5");
        run_op(2'b10, 4'b0101, 4'd15, "shift_srl15");
        run_op(2'b10, 4'b0100, 4'd1,  "shift_sll1");
        run_op(2'b10, 4'b0101, 4'd2,  "shift_srl2");
    endtask

    task automatic test_shift_zero();
        run_op(2'b10, 4'b0101, 4'd0, "shift_zero_srl");
        run_op(2'b10, 4'b0100, 4'd0, "shift_zero_sll");
    endtask

    task automatic test_illegal_busy();
        obs_t act;
        run_op(2'b10, 4'b1111, 4'd0, "illegal_f");
        run_op(2'b10, 4'b0111, 4'd4, "illegal_7");
        // Second Start during SHIFT must not disturb the 5-cycle trace
        model_request(2'b10, 4'b0100, 4'd5);
        @(negedge CLK);
        bus.ALUControl = 2'b10;
        bus.Opcode     = 4'b0100;
        bus.ShiftAmt   = 4'd5;
        bus.Start      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
            if (i == 1) begin
                bus.ALUControl = 2'b01;
                bus.ShiftAmt   = 4'd2;
                bus.Start      = 1'b1;
            end
            act = observe();
            n_checks++;
            if (act !== m_q[i]) begin
                n_fail++;
                $display("FAIL busy_ignore cycle %0d: got %b want %b", i, act, m_q[i]);
            end
        end
        @(negedge CLK);
        act = observe();
        n_checks++;
        if (act !== idle_obs(3'd4)) begin
            n_fail++;
            $display("FAIL busy_ignore idle: got %b want %b", act, idle_obs(3'd4));
        end
        m_last_op = 3'd4;
    endtask

    task automatic test_flush();
        obs_t act;
        model_request(2'b10, 4'b0100, 4'd4);
        @(negedge CLK);
        bus.ALUControl = 2'b10;
        bus.Opcode     = 4'b0100;
        bus.ShiftAmt   = 4'd4;
        bus.Start      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
            act = observe();
            n_checks++;
            if (act !== m_q[i]) begin
                n_fail++;
                $display("FAIL flush_pre cycle %0d: got %b want %b", i, act, m_q[i]);
            end
        end
        bus.Flush = 1'b1;
        @(negedge CLK);
        bus.Flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            act = observe();
            n_checks++;
            if (act !== idle_obs(3'd4)) begin
                n_fail++;
                $display("FAIL flush_idle cycle %0d: got %b want %b", i, act, idle_obs(3'd4));
            end
            @(negedge CLK);
        end
        bus.ALUControl = 2'b01;
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        @(negedge CLK);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act = observe();
            n_checks++;
            if (act !== idle_obs(3'd4)) begin
                n_fail++;
                $display("FAIL flush_start cycle %0d: got %b want %b", i, act, idle_obs(3'd4));
            end
            @(negedge CLK);
        end
        m_last_op = 3'd4;
    endtask

    task automatic test_random();
        logic [1:0] ctl;
        logic [3:0] opc;
        logic [3:0] amt;
        for (int n = 0; n < 40; n++) begin
            ctl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) ctl = 2'b10;
            opc = 4'($urandom_range(0, 15));
            amt = 4'($urandom_range(0, 15));
            run_op(ctl, opc, amt, "random");
        end
    endtask

    initial begin
        Reset_n        = 1'b0;
        bus.Start      = 1'b0;
        bus.Flush      = 1'b0;
        bus.ALUControl = 2'b00;
        bus.Opcode     = 4'b0000;
        bus.ShiftAmt   = 4'd0;
        m_last_op      = 3'd0;
        #2;
        test_reset();
        test_single_cycle();
        test_shift();
        test_shift_zero();
        test_illegal_busy();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
